uart_tx_fifo: RTL and testbench

//   Byte buffer and pacer directly upstream of the UART transmitter (Send).
//   The LC-3 output path pushes bytes at CPU speed; this block stores up to DEPTH

---
 rtl/uart_tx_fifo.sv | 123 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO in front of the UART transmitter (Send).
// Send has no ready handshake, so bytes are issued as one-cycle strobes
// spaced at least FRAME_CYCLES apart. A single down-counter times the gap,
// and the next byte issues on the cycle the counter reaches zero.
//
//   state  | meaning
//   IDLE   | nothing in flight; issue as soon as the FIFO holds a byte
//   GAP    | a byte was issued; wait for gap_cnt to reach 0 before the next one
module uart_tx_fifo #(
  parameter int DEPTH        = 16,
  parameter int AW           = 4,
  parameter int FRAME_CYCLES = 104170,
  parameter int GW           = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          busy,
  output logic          dout_vld,
  output logic [7:0]    dout_data
);

  typedef enum logic {S_IDLE, S_GAP} state_t;

  localparam logic [GW-1:0] GAP_RELOAD = GW'(FRAME_CYCLES - 1);
  localparam logic [AW:0]   CNT_FULL   = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q;
  logic          dout_vld_q;
  logic [7:0]    dout_data_q;
  logic [GW-1:0] gap_q, gap_d;
  state_t        state_q, state_d;
  logic          push, issue;

  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q != S_IDLE);
  assign dout_vld  = dout_vld_q;
  assign dout_data = dout_data_q;

  // A push while full is dropped, even when a pop happens on the same edge.
  assign push    = wr_en && !full;
  assign count_d = count_q + (AW+1)'(push) - (AW+1)'(issue);

  // Next-state, issue decision and gap timer update.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    issue   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          issue   = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else if (!empty) begin
          issue = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (issue) gap_d = GAP_RELOAD;
  end

  // FSM state and gap counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  // Storage array; contents are don't-care after reset since pointers restart.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // Pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (issue) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (wr_en && full) overflow_q <= 1'b1;
    end
  end

  // Registered output strobe and byte; the byte holds until the next issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_vld_q  <= 1'b0;
      dout_data_q <= 8'h00;
    end else begin
      dout_vld_q <= issue;
      if (issue) dout_data_q <= mem_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a short frame (20 cycles) and 4 entries.
module tb_uart_tx_fifo;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int FRAME = 20;
  localparam int GW    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full, empty, overflow, busy, dout_vld;
  logic [AW:0]   count;
  logic [7:0]    dout_data;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW), .FRAME_CYCLES(FRAME), .GW(GW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .busy(busy), .dout_vld(dout_vld), .dout_data(dout_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       vld;
    logic [7:0] data;
    int         cnt;
    logic       full;
    logic       empty;
    logic       busy;
    logic       ovf;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      rst     = vecs[i].rst;
      wr_en   = vecs[i].wr_en;
      wr_data = vecs[i].wr_data;
      tick();
      chk($sformatf("v%0d_vld", i),   int'(dout_vld),  int'(vecs[i].vld));
      chk($sformatf("v%0d_data", i),  int'(dout_data), int'(vecs[i].data));
      chk($sformatf("v%0d_count", i), int'(count),     vecs[i].cnt);
      chk($sformatf("v%0d_full", i),  int'(full),      int'(vecs[i].full));
      chk($sformatf("v%0d_empty", i), int'(empty),     int'(vecs[i].empty));
      chk($sformatf("v%0d_busy", i),  int'(busy),      int'(vecs[i].busy));
      chk($sformatf("v%0d_ovf", i),   int'(overflow),  int'(vecs[i].ovf));
    end
    rst   = 1'b0;
    wr_en = 1'b0;
  endtask

  // Ticks until dout_vld is seen (bounded) and checks spacing and byte.
  task automatic wait_pulse(input int exp_n, input logic [7:0] exp_d, input string nm);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!dout_vld && n < exp_n + 5);
    chk({nm, "_spacing"}, n, exp_n);
    chk({nm, "_data"}, int'(dout_data), int'(exp_d));
  endtask

  task automatic put(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    int bad;
    //            rst  wr   data   vld  data   cnt full empty busy ovf
    vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 8'hA5, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hA5, 0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'hA5, 0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 8'h01, 1'b0, 8'hA5, 1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 8'h02, 1'b1, 8'h01, 1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 8'h03, 1'b0, 8'h01, 2, 1'b0, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00;

    // Reset, then a single byte A5 and its first cycles.
    run_vecs(0, 4);
    bad = 0;
    for (int i = 0; i < FRAME - 2; i++) begin
      tick();
      if (!busy || dout_vld) bad++;
    end
    chk("single_gap_busy_hold", bad, 0);
    tick();
    chk("single_back_to_idle", int'(busy), 0);

    // Burst 01,02,03; 01 issues on the edge after its write.
    run_vecs(5, 7);
    wait_pulse(FRAME - 1, 8'h02, "burst_b2");
    chk("burst_count_after_b2", int'(count), 1);
    wait_pulse(FRAME, 8'h03, "burst_b3");
    chk("burst_count_after_b3", int'(count), 0);
    repeat (FRAME) tick();
    chk("burst_idle", int'(busy), 0);

    // Overflow: EE starts a gap, then 10..14 back to back into an empty FIFO.
    put(8'hEE);
    tick();
    chk("ovf_ee_vld", int'(dout_vld), 1);
    chk("ovf_ee_data", int'(dout_data), 8'hEE);
    put(8'h10);
    put(8'h11);
    put(8'h12);
    chk("ovf_full_before_4th", int'(full), 0);
    put(8'h13);
    chk("ovf_full_after_4th", int'(full), 1);
    chk("ovf_count_4", int'(count), DEPTH);
    chk("ovf_flag_before_5th", int'(overflow), 0);
    put(8'h14);
    chk("ovf_flag_after_5th", int'(overflow), 1);
    chk("ovf_count_still_4", int'(count), DEPTH);
    wait_pulse(FRAME - 5, 8'h10, "ovf_b10");
    chk("ovf_count_3", int'(count), DEPTH - 1);

    // Write on the same edge as an issue with count = DEPTH-1; 15 lands past the wrap.
    bad = 0;
    for (int i = 0; i < FRAME - 1; i++) begin
      tick();
      if (dout_vld) bad++;
    end
    chk("wrap_no_early_pulse", bad, 0);
    put(8'h15);
    chk("wrap_issue_vld", int'(dout_vld), 1);
    chk("wrap_issue_data", int'(dout_data), 8'h11);
    chk("wrap_count_same", int'(count), DEPTH - 1);
    chk("wrap_full_low", int'(full), 0);
    wait_pulse(FRAME, 8'h12, "wrap_b12");
    wait_pulse(FRAME, 8'h13, "wrap_b13");
    wait_pulse(FRAME, 8'h15, "wrap_b15");
    chk("wrap_drained", int'(empty), 1);
    chk("ovf_sticky", int'(overflow), 1);
    repeat (FRAME) tick();
    chk("wrap_idle", int'(busy), 0);

    // Reset in the middle of a gap with three bytes queued.
    put(8'h20);
    put(8'h21);
    put(8'h22);
    put(8'h23);
    chk("rst_pre_count", int'(count), 3);
    chk("rst_pre_busy", int'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_vld", int'(dout_vld), 0);
    chk("rst_data", int'(dout_data), 0);
    bad = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (dout_vld || busy) bad++;
    end
    chk("rst_quiet", bad, 0);
    put(8'h30);
    chk("post_rst_no_bypass", int'(dout_vld), 0);
    tick();
    chk("post_rst_vld", int'(dout_vld), 1);
    chk("post_rst_data", int'(dout_data), 8'h30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
